// File: rtl/application_selector_cpu_oci_pkg.sv
// rtl/application_selector_cpu_oci_pkg.sv - shared constants and state encoding for the OCI trace packer
package application_selector_cpu_oci_pkg;

    localparam int DCT_FRAME_W         = 2;
    localparam int DCT_FRAMES_PER_WORD = 15;
    localparam int DCT_CNT_W           = 4;
    localparam int DCT_WORD_W          = DCT_FRAME_W * DCT_FRAMES_PER_WORD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ENDED = 2'd3
    } dct_state_e;

    // True when the accumulator holds a complete word worth of frames
    function automatic logic dct_word_full(input logic [DCT_CNT_W-1:0] cnt);
        return cnt == DCT_CNT_W'(DCT_FRAMES_PER_WORD);
    endfunction

endpackage

// File: rtl/application_selector_cpu_oci_dct_accum.sv
// rtl/application_selector_cpu_oci_dct_accum.sv - frame shift accumulator feeding the dct output word
module application_selector_cpu_oci_dct_accum
    import application_selector_cpu_oci_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   accept,
    input  logic                   transfer,
    input  logic [DCT_FRAME_W-1:0] frame_data,
    output logic [DCT_WORD_W-1:0]  acc_buf,
    output logic [DCT_CNT_W-1:0]   acc_cnt
);

    // Shift in accepted frames; a transfer empties the accumulator, and a frame
    // accepted on the same edge becomes the first frame of the next word
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_buf <= '0;
            acc_cnt <= '0;
        end else if (transfer && accept) begin
            acc_buf <= {{(DCT_WORD_W-DCT_FRAME_W){1'b0}}, frame_data};
            acc_cnt <= DCT_CNT_W'(1);
        end else if (transfer) begin
            acc_buf <= '0;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_buf <= {acc_buf[DCT_WORD_W-DCT_FRAME_W-1:0], frame_data};
            acc_cnt <= acc_cnt + DCT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/application_selector_cpu_oci_dct_packer.sv
// rtl/application_selector_cpu_oci_dct_packer.sv - packs 2-bit trace frames into 30-bit dct_buffer words
module application_selector_cpu_oci_dct_packer
    import application_selector_cpu_oci_pkg::*;
#(
    parameter int FRAME_W         = DCT_FRAME_W,
    parameter int FRAMES_PER_WORD = DCT_FRAMES_PER_WORD
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               trc_on,
    input  logic                               frame_valid,
    input  logic [FRAME_W-1:0]                 frame_data,
    output logic                               frame_ready,
    input  logic                               stop_req,
    output logic [FRAME_W*FRAMES_PER_WORD-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0]               dct_count,
    output logic                               dct_valid,
    input  logic                               dct_ready,
    output logic                               test_ending,
    output logic                               test_has_ended
);

    dct_state_e            state;
    dct_state_e            state_nxt;
    logic [DCT_WORD_W-1:0] acc_buf;
    logic [DCT_CNT_W-1:0]  acc_cnt;
    logic                  xfer_ok;
    logic                  acc_full;
    logic                  accept;
    logic                  transfer;

    assign xfer_ok  = !dct_valid || dct_ready;
    assign acc_full = dct_word_full(acc_cnt);
    assign accept   = frame_valid && frame_ready;

    application_selector_cpu_oci_dct_accum u_accum (
        .clk        (clk),
        .reset_n    (reset_n),
        .accept     (accept),
        .transfer   (transfer),
        .frame_data (frame_data),
        .acc_buf    (acc_buf),
        .acc_cnt    (acc_cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, frame handshake and accumulator-to-output transfer decision
    always_comb begin
        state_nxt      = state;
        frame_ready    = 1'b0;
        transfer       = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trc_on) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A full accumulator can still take a frame if its word leaves this cycle
                frame_ready = !acc_full || xfer_ok;
                transfer    = acc_full && xfer_ok;
                if (stop_req || !trc_on) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                test_ending = 1'b1;
                transfer    = (acc_cnt != '0) && xfer_ok;
                if ((acc_cnt == '0) && !dct_valid) begin
                    state_nxt = ST_ENDED;
                end
            end
            ST_ENDED: begin
                test_has_ended = 1'b1;
                if (!trc_on) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output word register: load on transfer, hold until consumed
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            dct_valid  <= 1'b0;
        end else if (transfer) begin
            dct_buffer <= acc_buf;
            dct_count  <= acc_cnt;
            dct_valid  <= 1'b1;
        end else if (dct_valid && dct_ready) begin
            dct_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_application_selector_cpu_oci_dct_packer.sv
// tb/tb_application_selector_cpu_oci_dct_packer.sv - self-checking bench for the OCI dct packer
module tb_application_selector_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trc_on = 1'b0;
    logic        frame_valid = 1'b0;
    logic [1:0]  frame_data = 2'b00;
    logic        frame_ready;
    logic        stop_req = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready = 1'b0;
    logic        test_ending;
    logic        test_has_ended;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    application_selector_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trc_on         (trc_on),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_ready    (frame_ready),
        .stop_req       (stop_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        reset_n = 1'b0; trc_on = 1'b0; frame_valid = 1'b0; frame_data = 2'b00;
        stop_req = 1'b0; dct_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] f);
        int n = 0;
        frame_valid = 1'b1;
        frame_data  = f;
        forever begin
            @(negedge clk);
            if (frame_ready || n >= 64) break;
            tick();
            n++;
        end
        expect_eq("send_timeout", n < 64, 1);
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!dct_valid && n < 40) begin
            tick();
            @(negedge clk);
            n++;
        end
        expect_eq(tag, n < 40, 1);
    endtask

    task automatic stop_and_drain(input string tag);
        int n = 0;
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        @(negedge clk);
        while (!test_has_ended && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        expect_eq(tag, n < 100, 1);
        tick();
    endtask

    // Reference model: every accepted frame is queued in order; each consumed
    // word must be the next 15 frames (or the remaining tail when flushing),
    // first-accepted frame in the highest occupied slot
    logic [1:0]  exp_q[$];
    logic        prev_hold = 1'b0;
    logic        prev_ended = 1'b0;
    logic [29:0] prev_buf;
    logic [3:0]  prev_cnt;
    int          mon_n;
    logic [29:0] mon_w;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                prev_hold  = 1'b0;
                prev_ended = 1'b0;
            end else begin
                if (prev_hold) begin
                    expect_eq("hold_valid", dct_valid, 1);
                    expect_eq("hold_buf", dct_buffer, prev_buf);
                    expect_eq("hold_cnt", dct_count, prev_cnt);
                end
                if (test_ending || test_has_ended)
                    expect_eq("ready_outside_run", frame_ready, 0);
                if (dct_valid && dct_ready) begin
                    mon_n = (exp_q.size() >= 15) ? 15 : exp_q.size();
                    if (mon_n == 0)
                        expect_eq("spurious_word", dct_valid, 0);
                    mon_w = '0;
                    for (int i = 0; i < mon_n; i++)
                        mon_w = {mon_w[27:0], exp_q[i]};
                    expect_eq("word_cnt", dct_count, mon_n);
                    expect_eq("word_buf", dct_buffer, mon_w);
                    if (mon_n < 15)
                        expect_eq("partial_only_in_flush", test_ending, 1);
                    for (int i = 0; i < mon_n; i++)
                        void'(exp_q.pop_front());
                end
                if (frame_valid && frame_ready)
                    exp_q.push_back(frame_data);
                if (test_has_ended && !prev_ended)
                    expect_eq("drained", exp_q.size(), 0);
                prev_ended = test_has_ended;
                prev_hold  = dct_valid && !dct_ready;
                prev_buf   = dct_buffer;
                prev_cnt   = dct_count;
            end
        end
    end

    initial begin
        int acc;
        int words;
        int n;
        int extra;

        // Reset state
        rst();
        @(negedge clk);
        expect_eq("rst_valid", dct_valid, 0);
        expect_eq("rst_buf", dct_buffer, 0);
        expect_eq("rst_cnt", dct_count, 0);
        expect_eq("rst_ready", frame_ready, 0);
        expect_eq("rst_ending", test_ending, 0);
        expect_eq("rst_ended", test_has_ended, 0);

        // One full word of 2'b01 frames
        tick();
        trc_on = 1'b1; dct_ready = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) send(2'b01);
        wait_valid("full_wait");
        expect_eq("full_buf", dct_buffer, 30'h15555555);
        expect_eq("full_cnt", dct_count, 15);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (dct_valid) extra++;
        end
        expect_eq("full_no_extra", extra, 0);
        tick();
        stop_and_drain("full_end_timeout");
        trc_on = 1'b0;
        tick();
        @(negedge clk);
        expect_eq("full_back_idle", test_has_ended, 0);

        // Backpressure: 30 frames fit, 31st waits for the output to drain
        tick();
        rst();
        trc_on = 1'b1; dct_ready = 1'b0;
        frame_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            frame_data = 2'($urandom);
            @(negedge clk);
            if (frame_valid && frame_ready) acc++;
            tick();
        end
        @(negedge clk);
        expect_eq("bp_accepted", acc, 30);
        expect_eq("bp_ready_low", frame_ready, 0);
        tick();
        dct_ready = 1'b1;
        words = 0;
        n = 0;
        while (acc < 31 && n < 10) begin
            @(negedge clk);
            if (frame_valid && frame_ready) acc++;
            if (dct_valid && dct_ready) words++;
            tick();
            n++;
        end
        frame_valid = 1'b0;
        expect_eq("bp_31st", acc, 31);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dct_valid && dct_ready) words++;
            tick();
        end
        expect_eq("bp_words", words, 2);
        stop_and_drain("bp_end_timeout");

        // Partial flush of three frames
        rst();
        trc_on = 1'b1; dct_ready = 1'b1;
        tick();
        send(2'b11); send(2'b10); send(2'b01);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        @(negedge clk);
        expect_eq("pf_ending", test_ending, 1);
        wait_valid("pf_wait");
        expect_eq("pf_buf", dct_buffer, 30'h39);
        expect_eq("pf_cnt", dct_count, 3);
        n = 0;
        while (!test_has_ended && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        expect_eq("pf_ended", test_has_ended, 1);

        // Empty stop, plus stop_req ignored while idle
        tick();
        trc_on = 1'b0;
        tick();
        @(negedge clk);
        expect_eq("es_idle", test_has_ended, 0);
        tick();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        @(negedge clk);
        expect_eq("es_idle_stop_ignored", test_ending, 0);
        tick();
        trc_on = 1'b1;
        tick();
        @(negedge clk);
        expect_eq("es_run_ready", frame_ready, 1);
        expect_eq("es_run_not_ending", test_ending, 0);
        tick();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        @(negedge clk);
        expect_eq("es_flush", test_ending, 1);
        expect_eq("es_flush_novalid", dct_valid, 0);
        tick();
        @(negedge clk);
        expect_eq("es_ended", test_has_ended, 1);
        expect_eq("es_not_ending", test_ending, 0);
        expect_eq("es_ended_novalid", dct_valid, 0);
        tick();
        trc_on = 1'b0;
        tick();
        @(negedge clk);
        expect_eq("es_to_idle", test_has_ended, 0);

        // Transfer, consume and accept on the same edge
        tick();
        rst();
        trc_on = 1'b1; dct_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) send(2'b11);
        for (int i = 0; i < 15; i++) send(2'b01);
        @(negedge clk);
        expect_eq("sim_old_valid", dct_valid, 1);
        expect_eq("sim_old_buf", dct_buffer, 30'h3FFFFFFF);
        expect_eq("sim_full_ready", frame_ready, 0);
        tick();
        dct_ready = 1'b1; frame_valid = 1'b1; frame_data = 2'b10;
        @(negedge clk);
        expect_eq("sim_ready", frame_ready, 1);
        tick();
        frame_valid = 1'b0;
        @(negedge clk);
        expect_eq("sim_new_valid", dct_valid, 1);
        expect_eq("sim_new_buf", dct_buffer, 30'h15555555);
        expect_eq("sim_new_cnt", dct_count, 15);
        tick();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        wait_valid("sim_tail_wait");
        expect_eq("sim_tail_buf", dct_buffer, 30'h2);
        expect_eq("sim_tail_cnt", dct_count, 1);

        // Reset while a flushed word is still waiting
        tick();
        rst();
        trc_on = 1'b1; dct_ready = 1'b0;
        tick();
        send(2'b10); send(2'b01); send(2'b11);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        wait_valid("rf_wait");
        expect_eq("rf_in_flush", test_ending, 1);
        tick();
        reset_n = 1'b0; trc_on = 1'b0;
        tick();
        @(negedge clk);
        expect_eq("rf_valid", dct_valid, 0);
        expect_eq("rf_buf", dct_buffer, 0);
        expect_eq("rf_cnt", dct_count, 0);
        expect_eq("rf_ready", frame_ready, 0);
        expect_eq("rf_ending", test_ending, 0);
        expect_eq("rf_ended", test_has_ended, 0);
        tick();
        reset_n = 1'b1;

        // Randomized runs against the queue model
        for (int r = 0; r < 6; r++) begin
            rst();
            trc_on = 1'b1;
            tick();
            for (int c = 0; c < 300; c++) begin
                frame_valid = ($urandom_range(0, 3) != 0);
                frame_data  = 2'($urandom);
                dct_ready   = ($urandom_range(0, 4) != 0);
                if (c == 299 || $urandom_range(0, 249) == 0) begin
                    if ($urandom_range(0, 1) != 0) stop_req = 1'b1;
                    else trc_on = 1'b0;
                    tick();
                    stop_req = 1'b0;
                    break;
                end
                tick();
            end
            n = 0;
            while (n < 300) begin
                @(negedge clk);
                if (test_has_ended) break;
                tick();
                frame_valid = ($urandom_range(0, 1) != 0);
                frame_data  = 2'($urandom);
                dct_ready   = ($urandom_range(0, 4) != 0);
                n++;
            end
            expect_eq("rand_end_timeout", n < 300, 1);
            tick();
            trc_on = 1'b0; frame_valid = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
